io_bank: RTL

Parametrised I/O subsystem for the next-generation single-cycle CPU, replacing the fixed two-input/four-output wiring with N_IN handshaked input channels and N_OUT registered output channels. Each input channel buffers producer data in a small FIFO, and the CPU reads it combinationally within its single cycle. A read from an empty channel raises `stall`, which freezes the PC and all register writes until data arrives. Writes to output channels update a register and emit a one-cycle strobe.

---
 rtl/io_bank_pkg.sv | 33 +++
 rtl/io_fifo.sv | 69 ++++++
 rtl/io_bank.sv | 101 ++++++++++
 3 files changed

// File: rtl/io_bank_pkg.sv
// Shared constants for the CPU I/O subsystem: channel defaults, the I/O opcode
// field layout used by the control unit, and small helpers for io_bank/io_fifo.
package io_bank_pkg;

    // Default channel geometry; the control unit and io_bank both read these.
    localparam int IO_WIDTH = 8;
    localparam int IO_N_IN  = 2;
    localparam int IO_N_OUT = 4;
    localparam int IO_DEPTH = 2;
    localparam int IO_AW    = 2;

    // CPU I/O instruction fields: opcode in [6:0], port number in [24:20].
    localparam int        OPC_LSB    = 0;
    localparam int        OPC_W      = 7;
    localparam logic [6:0] OPC_IO_IN  = 7'b0001011;
    localparam logic [6:0] OPC_IO_OUT = 7'b0101011;
    localparam int        PORT_LSB   = 20;
    localparam int        PORT_W     = 5;

    // Outcome of the CPU read request in the current cycle.
    typedef enum logic [1:0] {
        RD_IDLE,
        RD_HIT,
        RD_STALL,
        RD_OOR
    } rd_kind_e;

    // FIFO pointers carry one extra wrap bit so full and empty are distinguishable.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO for one input channel. Full/empty come from the
// pointer difference; the head entry is presented combinationally.
module io_fifo
    import io_bank_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int DEPTH = IO_DEPTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic             ready
);

    localparam int PW = ptr_width(DEPTH);
    localparam int IW = PW - 1;

    logic [PW-1:0]    wptr_q, wptr_d;
    logic [PW-1:0]    rptr_q, rptr_d;
    logic [PW-1:0]    count;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Status decode from registered pointers only, so ready never depends on the CPU read.
    always_comb begin
        count   = wptr_q - rptr_q;
        empty   = (count == '0);
        ready   = (count != PW'(DEPTH));
        head    = mem_q[rptr_q[IW-1:0]];
        do_push = push & ready;
        do_pop  = pop & ~empty;
    end

    // Next-state for storage and pointers; a full FIFO refuses the push even while popping.
    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (do_push) begin
            mem_d[wptr_q[IW-1:0]] = push_data;
            wptr_d                = wptr_q + PW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PW'(1);
        end
    end

    // State registers; reset discards every buffered word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            mem_q  <= mem_d;
        end
    end

endmodule

// File: rtl/io_bank.sv
// CPU I/O bank: N_IN buffered input channels read combinationally by the CPU
// (stalling on empty) and N_OUT output registers with one-cycle update strobes.
module io_bank
    import io_bank_pkg::*;
#(
    parameter int WIDTH = IO_WIDTH,
    parameter int N_IN  = IO_N_IN,
    parameter int N_OUT = IO_N_OUT,
    parameter int DEPTH = IO_DEPTH,
    parameter int AW    = IO_AW
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_addr,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   stall,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic [N_IN*WIDTH-1:0]  in_data,
    input  logic [N_IN-1:0]        in_valid,
    output logic [N_IN-1:0]        in_ready,
    output logic [N_OUT*WIDTH-1:0] out_data,
    output logic [N_OUT-1:0]       out_strobe
);

    logic [WIDTH-1:0]       head [N_IN];
    logic [N_IN-1:0]        empty;
    logic [N_IN-1:0]        pop;
    rd_kind_e               rd_kind;
    logic                   wr_fire;
    logic [N_OUT*WIDTH-1:0] out_data_q, out_data_d;
    logic [N_OUT-1:0]       out_strobe_q, out_strobe_d;

    for (genvar k = 0; k < N_IN; k++) begin : g_in
        io_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (in_valid[k]),
            .push_data (in_data[k*WIDTH +: WIDTH]),
            .pop       (pop[k]),
            .head      (head[k]),
            .empty     (empty[k]),
            .ready     (in_ready[k])
        );
    end

    // Classify the CPU read, select the FIFO head and request a pop on a hit.
    always_comb begin
        rd_kind = RD_IDLE;
        rd_data = '0;
        pop     = '0;
        if (rd_en) begin
            rd_kind = RD_OOR;
            for (int k = 0; k < N_IN; k++) begin
                if (rd_addr == AW'(k)) begin
                    if (empty[k]) begin
                        rd_kind = RD_STALL;
                    end else begin
                        rd_kind = RD_HIT;
                        rd_data = head[k];
                        pop[k]  = 1'b1;
                    end
                end
            end
        end
        stall = (rd_kind == RD_STALL);
    end

    // Output register next-state; a stalled cycle's write is dropped because the CPU repeats it.
    always_comb begin
        wr_fire      = wr_en & ~stall;
        out_data_d   = out_data_q;
        out_strobe_d = '0;
        for (int j = 0; j < N_OUT; j++) begin
            if (wr_fire && (wr_addr == AW'(j))) begin
                out_data_d[j*WIDTH +: WIDTH] = wr_data;
                out_strobe_d[j]              = 1'b1;
            end
        end
    end

    // Output registers and strobes, cleared immediately by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_data_q   <= '0;
            out_strobe_q <= '0;
        end else begin
            out_data_q   <= out_data_d;
            out_strobe_q <= out_strobe_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_strobe = out_strobe_q;

endmodule
